// File: rtl/spectro_pkg.sv
// Shared types and constants for the spectrogram output sequencer.
package spectro_pkg;

  // Bin word width; also the PISO width and the slot length in cycles.
  localparam int WORD_W = 12;

  // Default input buffer depth and frame length limit.
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_BINS   = 16;

  // Slot counter width: counts 0..WORD_W-1.
  localparam int SLOT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output.
// Pushes are refused when full even if a pop occurs in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/piso_word_sequencer.sv
// Buffers bin magnitudes and presents one word per WORD_W-cycle slot to the
// downstream PISO, with a load strobe, frame-start marker and frame overrun flag.
module piso_word_sequencer
  import spectro_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_BINS   = DEF_MAX_BINS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [WORD_W-1:0] bin_data,
  input  logic              bin_last,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic [WORD_W-1:0] piso_word,
  output logic              piso_sl,
  output logic              frame_sync,
  output logic              busy,
  output logic              frame_err
);

  localparam int WCNT_W = $clog2(MAX_BINS + 2);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MAX_BINS);
  localparam logic [WCNT_W-1:0] WCNT_SAT   = WCNT_W'(MAX_BINS + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);

  seq_state_t        state_r;
  seq_state_t        state_next_s;
  logic [SLOT_W-1:0] slot_cnt_r;
  logic [WCNT_W-1:0] word_cnt_r;
  logic              first_pending_r;
  logic [WORD_W:0]   fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic [WORD_W-1:0] piso_word_r;
  logic              piso_sl_r;
  logic              frame_sync_r;
  logic              busy_r;
  logic              frame_err_r;

  assign bin_ready   = !fifo_full_s;
  assign fifo_push_s = bin_valid && !fifo_full_s;
  assign piso_word   = piso_word_r;
  assign piso_sl     = piso_sl_r;
  assign frame_sync  = frame_sync_r;
  assign busy        = busy_r;
  assign frame_err   = frame_err_r;

  // Each entry carries the bin_last flag above the data word.
  sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   ({bin_last, bin_data}),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state logic; the FIFO head is consumed only in the single LOAD cycle.
  always_comb begin
    state_next_s = state_r;
    fifo_pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && !fifo_empty_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        fifo_pop_s   = 1'b1;
        state_next_s = SHIFT;
      end
      SHIFT: begin
        if (slot_cnt_r == SLOT_LAST) begin
          if (enable && !fifo_empty_s) begin
            state_next_s = LOAD;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = SHIFT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Slot position: LOAD is position 0, SHIFT runs positions 1..WORD_W-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
    end else begin
      case (state_r)
        LOAD:    slot_cnt_r <= SLOT_ONE;
        SHIFT:   slot_cnt_r <= slot_cnt_r + SLOT_ONE;
        default: slot_cnt_r <= '0;
      endcase
    end
  end

  // Output registers and frame accounting, all updated from the LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso_word_r     <= '0;
      piso_sl_r       <= 1'b0;
      frame_sync_r    <= 1'b0;
      busy_r          <= 1'b0;
      frame_err_r     <= 1'b0;
      first_pending_r <= 1'b1;
      word_cnt_r      <= '0;
    end else begin
      piso_sl_r    <= (state_r == LOAD);
      frame_sync_r <= (state_r == LOAD) && first_pending_r;
      busy_r       <= (state_next_s != IDLE);
      if (state_r == LOAD) begin
        piso_word_r     <= fifo_dout_s[WORD_W-1:0];
        first_pending_r <= fifo_dout_s[WORD_W];
        if (fifo_dout_s[WORD_W]) begin
          word_cnt_r <= '0;
        end else begin
          // word_cnt_r counts earlier words of this frame; reaching the limit
          // means the word being loaded now overruns the frame.
          if (word_cnt_r >= WCNT_LIMIT) begin
            frame_err_r <= 1'b1;
          end
          if (word_cnt_r != WCNT_SAT) begin
            word_cnt_r <= word_cnt_r + WCNT_ONE;
          end
        end
      end
    end
  end

endmodule
